mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the CPU's single memory port between two requesters: the multicycle CPU and a
//   program loader/debug port. Arbitrates, sequences each access over a fixed-latency
//   synchronous memory, and returns a one-cycle completion pulse with read data.
//   Sits between CPU/loader and the unified instruction/data memory.
// PARAMETERS
//   ADDR_W        32  address width
//   DATA_W        32  data width
//   MEM_LATENCY   1   edges from the mem_en cycle to the mem_rdata sample edge; legal 0..7
//   MAX_CPU_BURST 4   consecutive CPU grants allowed while the loader waits; legal 1..15
// PORTS
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   cpu_req    in   1       CPU access request, level
//   cpu_we     in   1       1 = write, 0 = read
//   cpu_addr   in   ADDR_W  byte address
//   cpu_wdata  in   DATA_W  write data
//   cpu_ready  out  1       one-cycle completion pulse
//   cpu_rdata  out  DATA_W  read data, valid with cpu_ready, held until next CPU read
//   ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_ready/ldr_rdata: loader copies of the cpu_* ports, same widths
//   mem_en     out  1       memory access strobe, one cycle per access
//   mem_we     out  1       memory write enable, high only with mem_en
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data
//   owner      out  1       0 = CPU, 1 = loader; owner of current/last access
// BEHAVIOUR
//   Reset: clk and reset are as stated above. While reset is low, all outputs are 0, the FSM is in
//     IDLE, cpu_streak = 0 and latency cnt = 0. Reset takes effect immediately (asynchronous).
//   FSM states: IDLE, ACCESS, WAIT, DONE.
//   - IDLE: winner is chosen at the edge if any req is high. At that edge, latch we/addr/wdata
//     and owner, then go to ACCESS. Stay in IDLE if no req is high.
//   - ACCESS: drive mem_en=1 and mem_we=latched we for exactly one cycle.
//     Write -> DONE. Read -> WAIT with cnt=MEM_LATENCY.
//   - WAIT: sample mem_rdata into the owner's rdata register at the edge where cnt==0,
//     then go to DONE. Otherwise decrement cnt.
//   - DONE: pulse owner's ready for one cycle, then go to IDLE.
//   Timing, counted from the grant edge (cycle 1 = ACCESS):
//     write ready in cycle 2; read ready in cycle MEM_LATENCY+3.
//   Minimum spacing between grants is one IDLE cycle.
//   Arbitration:
//     - Loader wins iff ldr_req && (!cpu_req || cpu_streak==MAX_CPU_BURST). Otherwise the CPU wins.
//     - On a CPU grant, cpu_streak increments if ldr_req is high, else clears to 0.
//     - On a loader grant, cpu_streak clears to 0.
//     - cpu_streak saturates at MAX_CPU_BURST.
//   Requester protocol:
//     - Hold req and fields stable until ready.
//     - In the cycle after ready, present req low or a new request.
//     - req and fields are ignored after the grant edge. A dropped req still completes, and
//       ready still pulses.
//   mem_addr/mem_wdata hold their latched values outside ACCESS; mem_en and mem_we are 0 outside ACCESS.
//   Writes never modify *_rdata. The non-owner's ready and rdata are unaffected.
//   Reset mid-operation: access abandoned, no ready pulse, FSM restarts in IDLE.
// TESTING
//   1 MEM_LATENCY=1, mem[0]=00a58513, CPU read addr 0 -> mem_en one cycle, addr 0;
//     cpu_ready cycle 4 after grant; cpu_rdata=00a58513.
//   2 Loader write addr 0x10 data 00100113 -> mem_en=mem_we=1 one cycle; ldr_ready cycle 2;
//     then CPU read of 0x10 returns 00100113, and ldr_rdata is unchanged.
//   3 Both req held continuously, MAX_CPU_BURST=4 -> owner sequence
//     C,C,C,C,L,C,C,C,C,L; ready never pulses for both at once.
//   4 MEM_LATENCY=0 read -> ready cycle 3; MEM_LATENCY=7 read -> ready cycle 10;
//     mem_en is high exactly once per access.
//   5 reset low during WAIT -> all outputs 0 immediately, no ready pulse; after release,
//     a CPU read of addr 4 completes normally with correct data.
//   6 cpu_req dropped in the cycle after grant -> access completes, cpu_ready pulses once,
//     FSM returns to IDLE and stays there with no req.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory port between the CPU and the loader/debug port.
// One access is in flight at a time; completion is a one-cycle ready pulse to the owner.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MEM_LATENCY   = 1,
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ready,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic              r_we;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic [3:0]        r_streak;
    logic [2:0]        r_cnt;

    logic              w_any_req;
    logic              w_streak_full;
    logic              w_ldr_win;

    // The loader only overrides a requesting CPU once the CPU has used up its burst allowance.
    always_comb begin
        w_any_req     = cpu_req | ldr_req;
        w_streak_full = (r_streak == 4'(MAX_CPU_BURST));
        w_ldr_win     = ldr_req & (~cpu_req | w_streak_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_owner     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_streak    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_ldr_win;
                        r_we    <= w_ldr_win ? ldr_we    : cpu_we;
                        r_addr  <= w_ldr_win ? ldr_addr  : cpu_addr;
                        r_wdata <= w_ldr_win ? ldr_wdata : cpu_wdata;
                        r_state <= S_ACCESS;
                        if (w_ldr_win || !ldr_req) begin
                            r_streak <= '0;
                        end else if (!w_streak_full) begin
                            r_streak <= r_streak + 4'd1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= 3'(MEM_LATENCY);
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_owner) begin
                            r_ldr_rdata <= mem_rdata;
                        end else begin
                            r_cpu_rdata <= mem_rdata;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (r_state == S_ACCESS);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_ready = (r_state == S_DONE) & ~r_owner;
    assign ldr_ready = (r_state == S_DONE) & r_owner;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;
    assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances (MEM_LATENCY 1, 0, 7) with memory models;
// a reference model predicts grants, timing and data, and a monitor compares whenever outputs fire.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    function automatic int unsigned lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 7);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h00a58513 : (32'hC0DE0000 + 32'(i) * 32'h00010111);
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req [NI];
    logic        cpu_we [NI];
    logic [31:0] cpu_addr [NI];
    logic [31:0] cpu_wdata [NI];
    logic        cpu_ready [NI];
    logic [31:0] cpu_rdata [NI];
    logic        ldr_req [NI];
    logic        ldr_we [NI];
    logic [31:0] ldr_addr [NI];
    logic [31:0] ldr_wdata [NI];
    logic        ldr_ready [NI];
    logic [31:0] ldr_rdata [NI];
    logic        mem_en [NI];
    logic        mem_we [NI];
    logic [31:0] mem_addr [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        own_o [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(lat_of(g)), .MAX_CPU_BURST(4)
        ) u_dut (
            .clk(clk), .reset(rst_n),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_ready(cpu_ready[g]), .cpu_rdata(cpu_rdata[g]),
            .ldr_req(ldr_req[g]), .ldr_we(ldr_we[g]), .ldr_addr(ldr_addr[g]),
            .ldr_wdata(ldr_wdata[g]), .ldr_ready(ldr_ready[g]), .ldr_rdata(ldr_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .owner(own_o[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Memory environment: synchronous memory whose read data is held until the next read.
    logic [31:0] env_mem [NI][64];
    initial begin
        for (int k = 0; k < NI; k++) begin
            mem_rdata[k] = '0;
            for (int i = 0; i < 64; i++) env_mem[k][i] = init_word(i);
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (mem_en[k]) begin
                    if (mem_we[k]) env_mem[k][mem_addr[k][7:2]] <= mem_wdata[k];
                    else           mem_rdata[k] <= env_mem[k][mem_addr[k][7:2]];
                end
            end
        end
    end

    typedef struct {
        int unsigned grant;
        int unsigned due;
        bit          owner;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          ka = 0;
    logic [31:0] ref_mem [NI][64];
    int unsigned streak [NI];
    logic [31:0] mon_cpu [NI];
    logic [31:0] mon_ldr [NI];
    bit          own_log[$];
    int unsigned e = 0;
    int unsigned free_e = 0;
    int unsigned en_seen = 0;

    // Reference model at each rising edge, monitor at each falling edge.
    initial begin
        exp_t x;
        exp_t f;
        bit   lw;
        for (int k = 0; k < NI; k++) begin
            streak[k] = 0; mon_cpu[k] = '0; mon_ldr[k] = '0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
        end
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                sbq.delete();
                free_e = 0;
                en_seen = 0;
                for (int k = 0; k < NI; k++) begin
                    streak[k] = 0; mon_cpu[k] = '0; mon_ldr[k] = '0;
                end
            end else if (e >= free_e && (cpu_req[ka] || ldr_req[ka])) begin
                lw = ldr_req[ka] && (!cpu_req[ka] || streak[ka] == 4);
                if (lw || !ldr_req[ka]) streak[ka] = 0;
                else if (streak[ka] < 4) streak[ka]++;
                x.owner = lw;
                x.we    = lw ? ldr_we[ka]    : cpu_we[ka];
                x.addr  = lw ? ldr_addr[ka]  : cpu_addr[ka];
                x.data  = lw ? ldr_wdata[ka] : cpu_wdata[ka];
                if (x.we) ref_mem[ka][x.addr[7:2]] = x.data;
                else      x.data = ref_mem[ka][x.addr[7:2]];
                x.grant = e;
                x.due   = x.we ? e + 2 : e + lat_of(ka) + 3;
                free_e  = x.due + 1;
                sbq.push_back(x);
            end
            e++;

            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    chk("reset_outputs_zero",
                        64'({mem_en[k], mem_we[k], cpu_ready[k], ldr_ready[k], own_o[k]}) |
                        64'(|{mem_addr[k], mem_wdata[k], cpu_rdata[k], ldr_rdata[k]}), 64'd0);
                end else if (k != ka) begin
                    if (mem_en[k] || cpu_ready[k] || ldr_ready[k])
                        chk("inactive_instance_quiet", 64'(k), 64'(ka));
                end else begin
                    if (mem_we[k] && !mem_en[k]) chk("mem_we_without_en", 64'(mem_we[k]), 64'd0);
                    if (mem_en[k]) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_mem_en", 64'(e), 64'hFFFF_FFFF);
                        end else begin
                            chk("mem_en_cycle", 64'(e), 64'(sbq[0].grant + 1));
                            chk("mem_addr", 64'(mem_addr[k]), 64'(sbq[0].addr));
                            chk("mem_we", 64'(mem_we[k]), 64'(sbq[0].we));
                            chk("owner_at_access", 64'(own_o[k]), 64'(sbq[0].owner));
                            if (sbq[0].we) chk("mem_wdata", 64'(mem_wdata[k]), 64'(sbq[0].data));
                            en_seen++;
                        end
                    end
                    if (cpu_ready[k] || ldr_ready[k]) begin
                        chk("both_ready", 64'(cpu_ready[k] && ldr_ready[k]), 64'd0);
                        if (sbq.size() == 0) begin
                            chk("unexpected_ready", 64'(e), 64'hFFFF_FFFF);
                        end else begin
                            f = sbq.pop_front();
                            own_log.push_back(own_o[k]);
                            chk("ready_owner", 64'({cpu_ready[k], ldr_ready[k]}),
                                f.owner ? 64'd1 : 64'd2);
                            chk("owner_out", 64'(own_o[k]), 64'(f.owner));
                            chk("ready_cycle", 64'(e), 64'(f.due));
                            chk("mem_en_count", 64'(en_seen), 64'd1);
                            en_seen = 0;
                            if (!f.we) begin
                                if (f.owner) mon_ldr[k] = f.data;
                                else         mon_cpu[k] = f.data;
                            end
                            chk("cpu_rdata", 64'(cpu_rdata[k]), 64'(mon_cpu[k]));
                            chk("ldr_rdata", 64'(ldr_rdata[k]), 64'(mon_ldr[k]));
                        end
                    end
                    if (sbq.size() > 0 && e > sbq[0].due) begin
                        chk("ready_missing", 64'(e), 64'(sbq[0].due));
                        f = sbq.pop_front();
                        en_seen = 0;
                    end
                end
            end
        end
    end

    // Issue one access and hold it until ready; returns just after the following rising edge.
    task automatic access(input int k, input bit who, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        if (who) begin ldr_we[k] = we; ldr_addr[k] = a; ldr_wdata[k] = d; ldr_req[k] = 1'b1; end
        else     begin cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d; cpu_req[k] = 1'b1; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(who ? ldr_ready[k] : cpu_ready[k]) && n < 100);
        if (n >= 100) chk("ready_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        if (who) ldr_req[k] = 1'b0;
        else     cpu_req[k] = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr(input int words);
        return 32'($urandom_range(0, words - 1)) << 2;
    endfunction

    initial begin
        int base;
        int cnt;
        logic [9:0] pat;
        for (int k = 0; k < NI; k++) begin
            cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            ldr_req[k] = 0; ldr_we[k] = 0; ldr_addr[k] = '0; ldr_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        access(0, 0, 0, 32'h0, 32'h0);
        chk("t1_cpu_rdata", 64'(cpu_rdata[0]), 64'h00a58513);

        access(0, 1, 1, 32'h10, 32'h00100113);
        access(0, 0, 0, 32'h10, 32'h0);
        chk("t2_cpu_rdata", 64'(cpu_rdata[0]), 64'h00100113);
        chk("t2_ldr_rdata_unchanged", 64'(ldr_rdata[0]), 64'h0);

        base = own_log.size();
        fork
            begin repeat (8) access(0, 0, 0, rnd_addr(16), 32'h0); end
            begin repeat (2) access(0, 1, 0, rnd_addr(16), 32'h0); end
        join
        pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            if (base + i < own_log.size()) chk($sformatf("t3_owner_seq_%0d", i),
                                               64'(own_log[base + i]), 64'(pat[i]));
            else chk($sformatf("t3_owner_seq_%0d_missing", i), 64'(own_log.size()), 64'(base + 10));
        end

        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    access(0, 0, 1'($urandom_range(0, 1)), rnd_addr(16), $urandom);
                end
            end
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
                    access(0, 1, 1'($urandom_range(0, 1)), rnd_addr(16), $urandom);
                end
            end
        join

        ka = 1;
        access(1, 0, 0, 32'h8, 32'h0);
        access(1, 1, 1, 32'h8, 32'h12345678);
        access(1, 1, 0, 32'h8, 32'h0);
        ka = 2;
        access(2, 0, 0, 32'hC, 32'h0);
        access(2, 1, 0, 32'h14, 32'h0);

        // Reset while a long-latency read sits in WAIT.
        cpu_we[2] = 0; cpu_addr[2] = 32'h18; cpu_wdata[2] = '0; cpu_req[2] = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0; cpu_req[2] = 1'b0;
        #1 chk("t5_async_reset_zero",
               64'({mem_en[2], mem_we[2], cpu_ready[2], ldr_ready[2], own_o[2]}) |
               64'(|{mem_addr[2], mem_wdata[2], cpu_rdata[2], ldr_rdata[2]}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(2, 0, 0, 32'h4, 32'h0);
        chk("t5_read_after_reset", 64'(cpu_rdata[2]), 64'(init_word(1)));

        ka = 0;
        cpu_we[0] = 0; cpu_addr[0] = 32'h20; cpu_wdata[0] = '0; cpu_req[0] = 1'b1;
        @(posedge clk); #1;
        cpu_req[0] = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_ready[0]) cnt++;
        end
        chk("t6_single_ready_after_drop", 64'(cnt), 64'd1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", e);
        $fatal(1, "simulation time limit");
    end

endmodule
